weight_bram_reader: RTL
=======================

Name: weight_bram_reader

Overview:
- Read-side sequencer for the per-lane weight buffer: one command drives all BAND_WIDTH independent read ports (enable + address per lane).
- Produces a diagonally skewed weight stream for the systolic array: lane i starts i cycles after lane 0.
- Tags the returning buffer data with per-lane valids; the buffer has a 1-cycle registered read.
- Sits between the layer controller (start/done handshake) and the weight buffer read ports.

Parameters:
- SRAM_DEPTH, 50, words per lane buffer; legal addresses are 0..SRAM_DEPTH-1.
- BAND_WIDTH, 16, number of lanes / read ports.
- DATA_WIDTH, 8, weight word width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start_i  input  1  command strobe; sampled only in IDLE.
- base_i  input  $clog2(SRAM_DEPTH)  first word address, common to all lanes.
- len_i  input  $clog2(SRAM_DEPTH+1)  words per lane.
- enb_o  output  1 x BAND_WIDTH (unpacked)  per-lane buffer read enable.
- addrb_o  output  $clog2(SRAM_DEPTH) x BAND_WIDTH (unpacked)  per-lane buffer read address.
- dob_i  input  DATA_WIDTH x BAND_WIDTH (unpacked)  per-lane buffer read data, valid 1 cycle after enb.
- data_o  output  DATA_WIDTH x BAND_WIDTH (unpacked)  per-lane weight to the array; equals dob_i.
- valid_o  output  1 x BAND_WIDTH (unpacked)  data_o[i] is valid this cycle.
- busy_o  output  1  command in progress.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (asynchronous, rstn=0): FSM goes to IDLE; the following are all 0: enb_o, addrb_o, valid_o, busy_o, done_o, err_o, the master counter, and the latched base/len. Reset mid-command aborts immediately; no done_o pulse. After rstn rises, the block waits for a new start.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start_i=1 sampled at edge T:
  - base_i >= SRAM_DEPTH: reject; err_o=1 in cycle T+1; stay IDLE; busy_o stays 0.
  - len_i = 0: go to DRAIN; done_o=1 in cycle T+1; no enb_o.
  - len_i > SRAM_DEPTH: clamp to SRAM_DEPTH.
  - Otherwise: latch base and L=len, clear cnt, go to RUN.
- RUN: master counter cnt runs 0..L+BAND_WIDTH-2, one step per cycle.
  - Lane i: enb_o[i] = 1 iff i <= cnt < i+L.
  - Lane i: addrb_o[i] = (base + cnt - i) mod SRAM_DEPTH, computed with explicit compare-subtract (no `%`).
  - addrb_o[i] holds its last value when enb_o[i]=0.
  - Leave RUN for DRAIN after cnt = L+BAND_WIDTH-2.
- DRAIN: one cycle; done_o=1; then IDLE.
- Outputs are registered. Command sampled at T:
  - lane i enb_o high in cycles T+1+i .. T+L+i;
  - valid_o[i] = enb_o[i] delayed 1 cycle;
  - busy_o high T+1 .. T+L+BAND_WIDTH;
  - done_o in T+L+BAND_WIDTH, coincident with the last valid_o[BAND_WIDTH-1].
- data_o[i] = dob_i[i] combinationally. The buffer output is already registered, so the block adds no extra latency.
- start_i while busy_o=1 (RUN or DRAIN) is ignored, with no err_o. The earliest new command is sampled in the first IDLE cycle after DRAIN.
- Address wrap: base+k >= SRAM_DEPTH wraps to base+k-SRAM_DEPTH. At most one wrap, since L <= SRAM_DEPTH.
- No backpressure: the array consumes every valid beat.

Test Plan:
- Reset, then len_i=4, base_i=0, start at T (defaults) -> lane0 enb T+1..T+4, addr 0,1,2,3; lane15 enb T+16..T+19, addr 0..3; valid_o[15] T+17..T+20; done_o only at T+20; busy_o T+1..T+20.
- base_i=48, len_i=4 -> every lane reads 48,49,0,1 in order; data_o[i] matches preloaded buffer words.
- len_i=0 -> done_o at T+1, busy_o stays 0, no enb_o; len_i=63 -> clamped to 50, lane0 enb for 50 cycles, done_o at T+66.
- base_i=50 -> err_o one-cycle pulse at T+1, no enb_o/busy_o/done_o; next valid start accepted normally.
- start_i pulsed at T+5 during a len=4 run -> ignored, timing identical to the first scenario; start in the cycle after done_o is accepted.
- rstn low at T+8 of a len=10 run -> all outputs 0 immediately, no done_o; fresh start after release completes with full timing.

Source files
------------

// File: rtl/weight_bram_reader.sv
// Read sequencer for the per-lane weight buffer: one command fans out to all
// lanes as a diagonally skewed read stream, with per-lane valids on the returned data.
module weight_bram_reader #(
    parameter int SRAM_DEPTH = 50,
    parameter int BAND_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    localparam int AW = $clog2(SRAM_DEPTH),
    localparam int LW = $clog2(SRAM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [AW-1:0]         base_i,
    input  logic [LW-1:0]         len_i,
    output logic                  enb_o   [BAND_WIDTH],
    output logic [AW-1:0]         addrb_o [BAND_WIDTH],
    input  logic [DATA_WIDTH-1:0] dob_i   [BAND_WIDTH],
    output logic [DATA_WIDTH-1:0] data_o  [BAND_WIDTH],
    output logic                  valid_o [BAND_WIDTH],
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // Master counter peaks at L+BAND_WIDTH-2; SW also holds base+cnt without overflow.
    localparam int CW = $clog2(SRAM_DEPTH + BAND_WIDTH);
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0] base_reg, base_next;
    logic [LW-1:0] len_reg, len_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          run_next;
    logic          base_bad;
    logic          len_over;
    logic [SW-1:0] last_cnt;

    assign base_bad = {1'b0, base_i} >= (AW+1)'(SRAM_DEPTH);
    assign len_over = len_i > LW'(SRAM_DEPTH);
    assign last_cnt = SW'(len_reg) + SW'(BAND_WIDTH - 2);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        len_next   = len_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        run_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (start_i) begin
                    if (base_bad) begin
                        err_next = 1'b1;
                    end else if (len_i == '0) begin
                        len_next   = '0;
                        state_next = DRAIN;
                        done_next  = 1'b1;
                    end else begin
                        base_next  = base_i;
                        len_next   = len_over ? LW'(SRAM_DEPTH) : len_i;
                        cnt_next   = '0;
                        state_next = RUN;
                        busy_next  = 1'b1;
                        run_next   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (SW'(cnt_reg) == last_cnt) begin
                    state_next = DRAIN;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    run_next = 1'b1;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            base_reg  <= '0;
            len_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
            len_reg   <= len_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign err_o  = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BAND_WIDTH; gi++) begin : g_lane
            localparam logic [SW-1:0] LANE = SW'(gi);
            logic          enb_reg, enb_next;
            logic          valid_reg;
            logic [AW-1:0] addr_reg;
            logic [SW-1:0] rel, sum, wrapped;

            assign rel      = SW'(cnt_next);
            assign enb_next = run_next && (rel >= LANE) && (rel < LANE + SW'(len_next));
            // Only meaningful while the lane is enabled, where cnt >= lane keeps it non-negative.
            assign sum      = SW'(base_next) + rel - LANE;
            assign wrapped  = (sum >= SW'(SRAM_DEPTH)) ? sum - SW'(SRAM_DEPTH) : sum;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    enb_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    addr_reg  <= '0;
                end else begin
                    enb_reg   <= enb_next;
                    valid_reg <= enb_reg;
                    if (enb_next) begin
                        addr_reg <= AW'(wrapped);
                    end
                end
            end

            assign enb_o[gi]   = enb_reg;
            assign addrb_o[gi] = addr_reg;
            assign valid_o[gi] = valid_reg;
            assign data_o[gi]  = dob_i[gi];
        end
    endgenerate

endmodule
